// File: rtl/nor4_response_checker.sv
// Response checker for the 4-input NOR lab block: waits for each stimulus vector to settle, checks outputs, tracks coverage.
// Optional first-failure capture (ff_vec/ff_obs/ff_valid) is enabled by defining NOR4_CHK_FIRSTFAIL_EN.
module nor4_response_checker #(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             ina,
  input  logic             inb,
  input  logic             inc,
  input  logic             ind,
  input  logic             oute,
  input  logic             outf,
  input  logic             outg,
  output logic [CNT_W-1:0] err_cnt,
  output logic [15:0]      covered,
  output logic             done,
  output logic             fail,
  output logic             chk_pulse
`ifdef NOR4_CHK_FIRSTFAIL_EN
  ,
  output logic [3:0]       ff_vec,
  output logic [2:0]       ff_obs,
  output logic             ff_valid
`endif
);

  localparam int unsigned SCNT_W = 8;
  localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, WAIT, CHECK} state_t;

  state_t            state_q, state_d;
  logic [SCNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]        prev_q, prev_d;
  logic [3:0]        vec;
  logic              mismatch_c;
  logic              do_check_c;
  logic [CNT_W-1:0]  err_d;
  logic [15:0]       covered_d;
  logic              fail_d;

  assign vec = {ina, inb, inc, ind};

  // Golden NOR functions against the live DUT outputs
  always_comb begin
    mismatch_c = (oute != ~(ina | inb)) ||
                 (outf != ~(inc | ind)) ||
                 (outg != ~(ina | inb | inc | ind));
  end

  assign do_check_c = (state_q == CHECK) && !clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prev_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
    end
  end

  // Next-state logic; clr and a dropped en override the normal sequence
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    if (clr) begin
      cnt_d = '0;
      if (en) begin
        state_d = SETTLE;
        prev_d  = vec;
      end else begin
        state_d = IDLE;
      end
    end else if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SETTLE;
          cnt_d   = '0;
          prev_d  = vec;
        end
        SETTLE: begin
          if (vec != prev_q) begin
            prev_d = vec;
            cnt_d  = '0;
          end else if (cnt_q == SETTLE_LAST) begin
            state_d = CHECK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + SCNT_W'(1);
          end
        end
        CHECK: begin
          state_d = WAIT;
        end
        WAIT: begin
          if (vec != prev_q) begin
            state_d = SETTLE;
            cnt_d   = '0;
            prev_d  = vec;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Statistics update; clr wins over a coincident CHECK
  always_comb begin
    err_d     = err_cnt;
    covered_d = covered;
    fail_d    = fail;
    if (clr) begin
      err_d     = '0;
      covered_d = '0;
      fail_d    = 1'b0;
    end else if (do_check_c) begin
      covered_d[prev_q] = 1'b1;
      if (mismatch_c) begin
        fail_d = 1'b1;
        if (err_cnt != {CNT_W{1'b1}}) begin
          err_d = err_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt   <= '0;
      covered   <= '0;
      done      <= 1'b0;
      fail      <= 1'b0;
      chk_pulse <= 1'b0;
    end else begin
      err_cnt   <= err_d;
      covered   <= covered_d;
      done      <= &covered_d;
      fail      <= fail_d;
      chk_pulse <= (state_d == CHECK) && !clr;
    end
  end

`ifdef NOR4_CHK_FIRSTFAIL_EN
  // Capture only the first mismatching check
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_vec   <= 4'b0000;
      ff_obs   <= 3'b000;
      ff_valid <= 1'b0;
    end else if (clr) begin
      ff_vec   <= 4'b0000;
      ff_obs   <= 3'b000;
      ff_valid <= 1'b0;
    end else if (do_check_c && mismatch_c && !ff_valid) begin
      ff_vec   <= vec;
      ff_obs   <= {oute, outf, outg};
      ff_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_nor4_response_checker.sv
// Directed self-checking bench for nor4_response_checker (SETTLE_CYC=4, CNT_W=8).
module tb_nor4_response_checker;

  logic       clk = 1'b0;
  logic       rst, en, clr;
  logic       ina, inb, inc, ind;
  logic       oute, outf, outg;
  logic       inv_all, force_g0;
  logic [7:0] err_cnt;
  logic [15:0] covered;
  logic       done, fail, chk_pulse;
`ifdef NOR4_CHK_FIRSTFAIL_EN
  logic [3:0] ff_vec;
  logic [2:0] ff_obs;
  logic       ff_valid;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int pulse_cnt = 0;

  always #5 clk = ~clk;

  // Lab DUT model: correct NOR, optionally inverted or with outg stuck low
  assign oute = inv_all ? (ina | inb) : ~(ina | inb);
  assign outf = inv_all ? (inc | ind) : ~(inc | ind);
  assign outg = force_g0 ? 1'b0 : (inv_all ? (ina | inb | inc | ind) : ~(ina | inb | inc | ind));

  always @(posedge clk) if (chk_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;

  nor4_response_checker #(.SETTLE_CYC(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .ina(ina), .inb(inb), .inc(inc), .ind(ind),
    .oute(oute), .outf(outf), .outg(outg),
    .err_cnt(err_cnt), .covered(covered), .done(done), .fail(fail),
    .chk_pulse(chk_pulse)
`ifdef NOR4_CHK_FIRSTFAIL_EN
    , .ff_vec(ff_vec), .ff_obs(ff_obs), .ff_valid(ff_valid)
`endif
  );

  task automatic drive_vec(input logic [3:0] v);
    {ina, inb, inc, ind} = v;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; clr = 1'b0; inv_all = 1'b0; force_g0 = 1'b0;
    drive_vec(4'h0);
    wait_cyc(3);
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
    n_cmp++; if (covered !== 16'h0000) begin n_bad++; $display("FAIL reset_covered: got %h expected 0000", covered); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (fail !== 1'b0) begin n_bad++; $display("FAIL reset_fail: got %b expected 0", fail); end
    n_cmp++; if (chk_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_chk_pulse: got %b expected 0", chk_pulse); end
    rst = 1'b0;
    wait_cyc(2);
  endtask

  task automatic test_sweep;
    int p0;
    p0 = pulse_cnt;
    en = 1'b1;
    for (int v = 0; v < 16; v++) begin
      if (v == 15) begin
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL sweep_done_early: got %b expected 0", done); end
      end
      drive_vec(4'(v));
      wait_cyc(20);
    end
    n_cmp++; if (pulse_cnt - p0 !== 16) begin n_bad++; $display("FAIL sweep_pulses: got %0d expected 16", pulse_cnt - p0); end
    n_cmp++; if (covered !== 16'hFFFF) begin n_bad++; $display("FAIL sweep_covered: got %h expected ffff", covered); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL sweep_done: got %b expected 1", done); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL sweep_err_cnt: got %0d expected 0", err_cnt); end
    n_cmp++; if (fail !== 1'b0) begin n_bad++; $display("FAIL sweep_fail: got %b expected 0", fail); end
  endtask

  task automatic test_single_mismatch;
    force_g0 = 1'b1;
    drive_vec(4'h0);
    clr = 1'b1;
    wait_cyc(1);
    clr = 1'b0;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL clr_done: got %b expected 0", done); end
    wait_cyc(20);
    n_cmp++; if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL mis_err_cnt: got %0d expected 1", err_cnt); end
    n_cmp++; if (fail !== 1'b1) begin n_bad++; $display("FAIL mis_fail: got %b expected 1", fail); end
    n_cmp++; if (covered !== 16'h0001) begin n_bad++; $display("FAIL mis_covered: got %h expected 0001", covered); end
`ifdef NOR4_CHK_FIRSTFAIL_EN
    n_cmp++; if (ff_vec !== 4'h0) begin n_bad++; $display("FAIL mis_ff_vec: got %h expected 0", ff_vec); end
    n_cmp++; if (ff_obs !== 3'b110) begin n_bad++; $display("FAIL mis_ff_obs: got %b expected 110", ff_obs); end
    n_cmp++; if (ff_valid !== 1'b1) begin n_bad++; $display("FAIL mis_ff_valid: got %b expected 1", ff_valid); end
`endif
    force_g0 = 1'b0;
  endtask

  task automatic test_latency;
    drive_vec(4'h5);
    for (int i = 1; i <= 6; i++) begin
      wait_cyc(1);
      n_cmp++;
      if (chk_pulse !== (i == 5)) begin
        n_bad++; $display("FAIL latency_pulse_%0d: got %b expected %b", i, chk_pulse, (i == 5));
      end
    end
    n_cmp++; if (covered !== 16'h0021) begin n_bad++; $display("FAIL latency_covered: got %h expected 0021", covered); end
  endtask

  task automatic test_toggle;
    int p0;
    drive_vec(4'h3);
    clr = 1'b1;
    wait_cyc(1);
    clr = 1'b0;
    p0 = pulse_cnt;
    for (int i = 0; i < 10; i++) begin
      drive_vec((i % 2 == 0) ? 4'hC : 4'h3);
      wait_cyc(2);
    end
    n_cmp++; if (pulse_cnt - p0 !== 0) begin n_bad++; $display("FAIL toggle_pulses: got %0d expected 0", pulse_cnt - p0); end
    n_cmp++; if (covered !== 16'h0000) begin n_bad++; $display("FAIL toggle_covered: got %h expected 0000", covered); end
    drive_vec(4'hA);
    wait_cyc(6);
    n_cmp++; if (pulse_cnt - p0 !== 1) begin n_bad++; $display("FAIL hold6_pulses: got %0d expected 1", pulse_cnt - p0); end
    n_cmp++; if (covered !== 16'h0400) begin n_bad++; $display("FAIL hold6_covered: got %h expected 0400", covered); end
  endtask

  task automatic test_hold_en;
    int p0;
    drive_vec(4'h7);
    clr = 1'b1;
    wait_cyc(1);
    clr = 1'b0;
    p0 = pulse_cnt;
    wait_cyc(100);
    n_cmp++; if (pulse_cnt - p0 !== 1) begin n_bad++; $display("FAIL hold100_pulses: got %0d expected 1", pulse_cnt - p0); end
    n_cmp++; if (covered !== 16'h0080) begin n_bad++; $display("FAIL hold100_covered: got %h expected 0080", covered); end
    drive_vec(4'h9);
    wait_cyc(2);
    en = 1'b0;
    wait_cyc(3);
    n_cmp++; if (pulse_cnt - p0 !== 1) begin n_bad++; $display("FAIL en_drop_pulses: got %0d expected 1", pulse_cnt - p0); end
    n_cmp++; if (covered !== 16'h0080) begin n_bad++; $display("FAIL en_drop_covered: got %h expected 0080", covered); end
    en = 1'b1;
    wait_cyc(20);
    n_cmp++; if (pulse_cnt - p0 !== 2) begin n_bad++; $display("FAIL en_raise_pulses: got %0d expected 2", pulse_cnt - p0); end
    n_cmp++; if (covered !== 16'h0280) begin n_bad++; $display("FAIL en_raise_covered: got %h expected 0280", covered); end
    en = 1'b0;
    wait_cyc(3);
    en = 1'b1;
    wait_cyc(20);
    n_cmp++; if (pulse_cnt - p0 !== 3) begin n_bad++; $display("FAIL recheck_pulses: got %0d expected 3", pulse_cnt - p0); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL recheck_err_cnt: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_saturate;
    drive_vec(4'hF);
    clr = 1'b1;
    wait_cyc(1);
    clr = 1'b0;
    inv_all = 1'b1;
    for (int pass = 0; pass < 20; pass++) begin
      for (int v = 0; v < 16; v++) begin
        drive_vec(4'(v));
        wait_cyc(6);
      end
      if (pass == 0) begin
        n_cmp++; if (err_cnt !== 8'd16) begin n_bad++; $display("FAIL sat_first_pass: got %0d expected 16", err_cnt); end
      end
    end
    n_cmp++; if (err_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_err_cnt: got %0d expected 255", err_cnt); end
    n_cmp++; if (fail !== 1'b1) begin n_bad++; $display("FAIL sat_fail: got %b expected 1", fail); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL sat_done: got %b expected 1", done); end
`ifdef NOR4_CHK_FIRSTFAIL_EN
    n_cmp++; if (ff_obs !== 3'b000) begin n_bad++; $display("FAIL sat_ff_obs: got %b expected 000", ff_obs); end
`endif
  endtask

  task automatic test_rst_clr;
    bit seen;
    drive_vec(4'h2);
    wait_cyc(2);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL async_rst_err_cnt: got %0d expected 0", err_cnt); end
    n_cmp++; if (covered !== 16'h0000) begin n_bad++; $display("FAIL async_rst_covered: got %h expected 0000", covered); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL async_rst_done: got %b expected 0", done); end
    n_cmp++; if (fail !== 1'b0) begin n_bad++; $display("FAIL async_rst_fail: got %b expected 0", fail); end
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(8);
    n_cmp++; if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL post_rst_err_cnt: got %0d expected 1", err_cnt); end
    drive_vec(4'h6);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      wait_cyc(1);
      if (chk_pulse === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL clr_check_timeout: got no chk_pulse expected one within 12 cycles"); end
    clr = 1'b1;
    wait_cyc(1);
    clr = 1'b0;
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL clr_err_cnt: got %0d expected 0", err_cnt); end
    n_cmp++; if (covered !== 16'h0000) begin n_bad++; $display("FAIL clr_covered: got %h expected 0000", covered); end
    n_cmp++; if (fail !== 1'b0) begin n_bad++; $display("FAIL clr_fail: got %b expected 0", fail); end
    n_cmp++; if (chk_pulse !== 1'b0) begin n_bad++; $display("FAIL clr_chk_pulse: got %b expected 0", chk_pulse); end
`ifdef NOR4_CHK_FIRSTFAIL_EN
    n_cmp++; if (ff_valid !== 1'b0) begin n_bad++; $display("FAIL clr_ff_valid: got %b expected 0", ff_valid); end
`endif
    inv_all = 1'b0;
  endtask

  initial begin
    test_reset;
    test_sweep;
    test_single_mismatch;
    test_latency;
    test_toggle;
    test_hold_en;
    test_saturate;
    test_rst_clr;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nor4_response_checker.md
Name: nor4_response_checker

Overview:
- Synthesizable self-checking monitor for the 4-input NOR lab block; the receiving end of the stimulus sweep.
- Watches the 4-bit stimulus vector `{ina,inb,inc,ind}` and the DUT outputs `oute`/`outf`/`outg`. Waits for each new vector to settle, then compares the outputs against the golden NOR functions.
- Counts mismatches and tracks which of the 16 input combinations have been checked.
- Sits beside the DUT on the lab board or in simulation; results drive LEDs/7-segment.

Parameters:
- `SETTLE_CYC`, 4, consecutive cycles a vector must be stable before it is checked (legal 1..255).
- `CNT_W`, 8, width of the mismatch counter.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  checker enable
- `clr`  in  1  synchronous clear of statistics
- `ina`, `inb`, `inc`, `ind`  in  1 each  stimulus applied to DUT (synchronous to `clk`)
- `oute`, `outf`, `outg`  in  1 each  DUT outputs
- `err_cnt`  out  CNT_W  saturating mismatch count
- `covered`  out  16  bit i set once vector i = `{ina,inb,inc,ind}` has been checked
- `done`  out  1  all 16 vectors covered
- `fail`  out  1  sticky, any mismatch seen
- `chk_pulse`  out  1  one-cycle strobe on each check

Behaviour:
- Golden functions:
  - `exp_e = ~(ina|inb)`
  - `exp_f = ~(inc|ind)`
  - `exp_g = ~(ina|inb|inc|ind)`
- Mismatch = any of the three outputs differs from its golden value.
- Reset (async, active-high):
  - `err_cnt`=0, `covered`=0, `done`=0, `fail`=0, `chk_pulse`=0.
  - FSM to IDLE, settle counter 0, previous-vector register 4'b0000.
- FSM states: IDLE, SETTLE, WAIT, CHECK.
  - IDLE: outputs hold. `en`=1 → SETTLE, counter=0, `prev`=current vector.
  - SETTLE:
    - Vector != `prev` → `prev`=vector, counter=0, stay in SETTLE.
    - Vector stable → counter+1.
    - Counter reaches `SETTLE_CYC`-1 while stable → CHECK.
  - CHECK (exactly one cycle):
    - `chk_pulse`=1.
    - `covered[prev]`=1.
    - On mismatch: `err_cnt`+1 (saturates at all-ones), `fail`=1.
    - Next state WAIT.
    - Comparison uses the vector and DUT outputs sampled in the CHECK cycle.
  - WAIT: vector != `prev` → SETTLE, counter=0, `prev`=vector. Otherwise stay; the same vector is never rechecked.
  - `en`=0 in any state → IDLE next cycle. A CHECK cycle in progress completes its update.
- Latency: a vector stable from cycle t is checked in cycle t+`SETTLE_CYC` (`chk_pulse` high that cycle); updated stats are visible at t+`SETTLE_CYC`+1.
- `done` = &`covered`, registered. It rises the cycle after the 16th distinct vector's CHECK.
- `clr`=1:
  - Zeroes `err_cnt`, `covered`, `done`, `fail` and `chk_pulse`, and forces the FSM to SETTLE (counter 0) if `en`, else IDLE.
  - `clr` has priority over a simultaneous CHECK update.
- Vector change in the CHECK cycle: the check still uses the sampled values, then WAIT sees the new vector and goes to SETTLE.
- `SETTLE_CYC`=1: CHECK follows one stable SETTLE cycle.
- Reset mid-SETTLE or mid-CHECK: no partial update survives.

Optional Feature:
- Macro: `NOR4_CHK_FIRSTFAIL_EN`.
- Defined:
  - Adds outputs `ff_vec` (4), `ff_obs` (3, `{oute,outf,outg}`), `ff_valid` (1).
  - `ff_vec` and `ff_obs` latch on the first mismatching CHECK only; `ff_valid`=1 afterward.
  - All three clear on `rst`/`clr` to 0.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Correct DUT model, `en`=1, vectors 0..15 each held 20 cycles → 16 `chk_pulse` strobes, `covered`=16'hFFFF, `done`=1, `err_cnt`=0, `fail`=0.
- Vector 4'b0000 with `outg` forced 0 → exactly one mismatch: `err_cnt`=1, `fail`=1. With the macro defined: `ff_vec`=0, `ff_obs`=3'b110.
- Vector toggles every 2 cycles, `SETTLE_CYC`=4 → zero `chk_pulse`, `covered` stays 0. Then hold 4'b1010 for 6 cycles → one check, `covered[10]`=1.
- Vector held 100 cycles → exactly one `chk_pulse`. `en` dropped mid-SETTLE and re-raised → stats unchanged, the vector is rechecked.
- All outputs inverted, vectors swept repeatedly 20 times → `err_cnt` saturates at 255, no wrap.
- Assert `rst` asynchronously mid-SETTLE, then `clr` during a CHECK cycle → all outputs 0 immediately on `rst`; after `clr`, `err_cnt`=0 and `covered`=0 with no update from the clashing CHECK.
